// File: rtl/dispatch4_buffer.sv
// Registered 4-way dispatcher: one tagged word per cycle is steered into one of
// four first-word-fall-through FIFOs, each drained by its own valid/ready consumer.
module dispatch4_buffer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,
    output logic [CNT_W-1:0] level0,
    output logic [CNT_W-1:0] level1,
    output logic [CNT_W-1:0] level2,
    output logic [CNT_W-1:0] level3,
    output logic             busy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_r   [4][DEPTH];
    logic [PTR_W-1:0] wptr_r  [4];
    logic [PTR_W-1:0] rptr_r  [4];
    logic [CNT_W-1:0] level_r [4];
    logic [WIDTH-1:0] head_s  [4];

    logic [3:0] full_s;
    logic [3:0] empty_s;
    logic [3:0] push_s;
    logic [3:0] pop_s;
    logic       accept_s;

    // Per-channel status flags and the push/pop strobes; flush masks both.
    always_comb begin
        full_s   = 4'b0000;
        empty_s  = 4'b0000;
        push_s   = 4'b0000;
        pop_s    = 4'b0000;
        accept_s = 1'b0;
        for (int i = 0; i < 4; i++) begin
            full_s[i]  = (level_r[i] == CNT_W'(DEPTH));
            empty_s[i] = (level_r[i] == CNT_W'(0));
        end
        in_ready = ~full_s[in_sel] & ~flush;
        accept_s = in_valid & in_ready;
        for (int i = 0; i < 4; i++) begin
            if (accept_s && (in_sel == 2'(i))) begin
                push_s[i] = 1'b1;
            end else begin
                push_s[i] = 1'b0;
            end
            pop_s[i] = ~empty_s[i] & out_ready[i] & ~flush;
        end
    end

    // Pointer and occupancy state; flush outranks any push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                wptr_r[i]  <= PTR_W'(0);
                rptr_r[i]  <= PTR_W'(0);
                level_r[i] <= CNT_W'(0);
            end
        end else if (flush) begin
            for (int i = 0; i < 4; i++) begin
                wptr_r[i]  <= PTR_W'(0);
                rptr_r[i]  <= PTR_W'(0);
                level_r[i] <= CNT_W'(0);
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (push_s[i]) begin
                    wptr_r[i] <= wptr_r[i] + PTR_W'(1);
                end
                if (pop_s[i]) begin
                    rptr_r[i] <= rptr_r[i] + PTR_W'(1);
                end
                case ({push_s[i], pop_s[i]})
                    2'b10:   level_r[i] <= level_r[i] + CNT_W'(1);
                    2'b01:   level_r[i] <= level_r[i] - CNT_W'(1);
                    default: level_r[i] <= level_r[i];
                endcase
            end
        end
    end

    // Storage is not reset; empty channels mask their head word instead.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (push_s[i]) begin
                mem_r[i][wptr_r[i]] <= in_data;
            end
        end
    end

    // Head words and status, all derived from registered state only.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            if (empty_s[i]) begin
                head_s[i] = '0;
            end else begin
                head_s[i] = mem_r[i][rptr_r[i]];
            end
        end
        out_valid = ~empty_s;
        busy      = |(~empty_s);
    end

    assign out_data0 = head_s[0];
    assign out_data1 = head_s[1];
    assign out_data2 = head_s[2];
    assign out_data3 = head_s[3];
    assign level0    = level_r[0];
    assign level1    = level_r[1];
    assign level2    = level_r[2];
    assign level3    = level_r[3];

endmodule

// File: tb/tb_dispatch4_buffer.sv
// Directed table-driven bench for dispatch4_buffer (WIDTH=16, DEPTH=4) with
// hand-written sequences for wrap-around, flush and asynchronous reset.
module tb_dispatch4_buffer;

    localparam int W  = 16;
    localparam int D  = 4;
    localparam int CW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_sel;
    logic [W-1:0]  in_data;
    logic [3:0]    out_valid;
    logic [3:0]    out_ready;
    logic [W-1:0]  out_data0, out_data1, out_data2, out_data3;
    logic [CW-1:0] level0, level1, level2, level3;
    logic          busy;

    int n_chk  = 0;
    int n_fail = 0;

    dispatch4_buffer #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data0(out_data0), .out_data1(out_data1),
        .out_data2(out_data2), .out_data3(out_data3),
        .level0(level0), .level1(level1), .level2(level2), .level3(level3),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [1:0]  sel;
        logic [15:0] d;
        logic [3:0]  ordy;
        logic        exp_rdy;
        logic [3:0]  exp_ov;
        logic [11:0] exp_lv;
        logic [63:0] exp_dat;
    } vec_t;

    vec_t tbl [15];

    function automatic vec_t mk(logic iv, logic [1:0] sel, logic [15:0] d, logic [3:0] ordy,
                                logic rdy, logic [3:0] ov, logic [11:0] lv, logic [63:0] dat);
        vec_t v;
        v.iv = iv; v.sel = sel; v.d = d; v.ordy = ordy;
        v.exp_rdy = rdy; v.exp_ov = ov; v.exp_lv = lv; v.exp_dat = dat;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [1:0] sel, input logic [15:0] d,
                         input logic [3:0] ordy);
        in_valid  = iv;
        in_sel    = sel;
        in_data   = d;
        out_ready = ordy;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_levels(input string nm, input logic [11:0] lv);
        chk(nm, {level3, level2, level1, level0}, lv);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0;
        drive(1'b0, 2'd0, 16'h0000, 4'b0000);

        // Reset / idle
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 4'b0000);
        chk_levels("rst_levels", 12'h000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_out_data", {out_data3, out_data2, out_data1, out_data0}, 64'h0);
        rst_n = 1'b1;
        for (int s = 0; s < 4; s++) begin
            in_sel = 2'(s);
            #1;
            chk("rst_in_ready", in_ready, 1'b1);
        end

        // Routing, then full/backpressure on ch2 with a ch1 push alongside
        tbl[0]  = mk(1'b1, 2'd0, 16'h1111, 4'b0000, 1'b1, 4'b0001,
                     {3'd0, 3'd0, 3'd0, 3'd1}, {16'h0, 16'h0, 16'h0, 16'h1111});
        tbl[1]  = mk(1'b1, 2'd1, 16'h2222, 4'b0000, 1'b1, 4'b0011,
                     {3'd0, 3'd0, 3'd1, 3'd1}, {16'h0, 16'h0, 16'h2222, 16'h1111});
        tbl[2]  = mk(1'b1, 2'd2, 16'h3333, 4'b0000, 1'b1, 4'b0111,
                     {3'd0, 3'd1, 3'd1, 3'd1}, {16'h0, 16'h3333, 16'h2222, 16'h1111});
        tbl[3]  = mk(1'b1, 2'd3, 16'h4444, 4'b0000, 1'b1, 4'b1111,
                     {3'd1, 3'd1, 3'd1, 3'd1}, {16'h4444, 16'h3333, 16'h2222, 16'h1111});
        tbl[4]  = mk(1'b0, 2'd0, 16'h0000, 4'b1111, 1'b1, 4'b0000,
                     12'h000, 64'h0);
        tbl[5]  = mk(1'b1, 2'd2, 16'h00A0, 4'b0000, 1'b1, 4'b0100,
                     {3'd0, 3'd1, 3'd0, 3'd0}, {16'h0, 16'h00A0, 16'h0, 16'h0});
        tbl[6]  = mk(1'b1, 2'd2, 16'h00A1, 4'b0000, 1'b1, 4'b0100,
                     {3'd0, 3'd2, 3'd0, 3'd0}, {16'h0, 16'h00A0, 16'h0, 16'h0});
        tbl[7]  = mk(1'b1, 2'd2, 16'h00A2, 4'b0000, 1'b1, 4'b0100,
                     {3'd0, 3'd3, 3'd0, 3'd0}, {16'h0, 16'h00A0, 16'h0, 16'h0});
        tbl[8]  = mk(1'b1, 2'd2, 16'h00A3, 4'b0000, 1'b1, 4'b0100,
                     {3'd0, 3'd4, 3'd0, 3'd0}, {16'h0, 16'h00A0, 16'h0, 16'h0});
        tbl[9]  = mk(1'b1, 2'd2, 16'h00BB, 4'b0000, 1'b0, 4'b0100,
                     {3'd0, 3'd4, 3'd0, 3'd0}, {16'h0, 16'h00A0, 16'h0, 16'h0});
        tbl[10] = mk(1'b1, 2'd1, 16'h00B0, 4'b0000, 1'b1, 4'b0110,
                     {3'd0, 3'd4, 3'd1, 3'd0}, {16'h0, 16'h00A0, 16'h00B0, 16'h0});
        tbl[11] = mk(1'b1, 2'd2, 16'h00BB, 4'b0100, 1'b0, 4'b0110,
                     {3'd0, 3'd3, 3'd1, 3'd0}, {16'h0, 16'h00A1, 16'h00B0, 16'h0});
        tbl[12] = mk(1'b0, 2'd1, 16'h0000, 4'b1111, 1'b1, 4'b0100,
                     {3'd0, 3'd2, 3'd0, 3'd0}, {16'h0, 16'h00A2, 16'h0, 16'h0});
        tbl[13] = mk(1'b0, 2'd0, 16'h0000, 4'b0100, 1'b1, 4'b0100,
                     {3'd0, 3'd1, 3'd0, 3'd0}, {16'h0, 16'h00A3, 16'h0, 16'h0});
        tbl[14] = mk(1'b0, 2'd0, 16'h0000, 4'b0100, 1'b1, 4'b0000,
                     12'h000, 64'h0);

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].iv, tbl[i].sel, tbl[i].d, tbl[i].ordy);
            #1;
            chk($sformatf("vec%0d_in_ready", i), in_ready, tbl[i].exp_rdy);
            cyc();
            chk($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].exp_ov);
            chk($sformatf("vec%0d_busy", i), busy, |tbl[i].exp_ov);
            chk_levels($sformatf("vec%0d_levels", i), tbl[i].exp_lv);
            chk($sformatf("vec%0d_out_data", i),
                {out_data3, out_data2, out_data1, out_data0}, tbl[i].exp_dat);
        end

        // Concurrent push and pop on ch0 at level 2, crossing pointer wrap
        drive(1'b1, 2'd0, 16'h00C0, 4'b0000); cyc();
        drive(1'b1, 2'd0, 16'h00C1, 4'b0000); cyc();
        chk("cc_level_pre", level0, 3'd2);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 2'd0, 16'(16'h00C2 + k), 4'b0001);
            #1;
            chk($sformatf("cc_head%0d", k), out_data0, 16'(16'h00C0 + k));
            chk($sformatf("cc_ready%0d", k), in_ready, 1'b1);
            cyc();
            chk($sformatf("cc_level%0d", k), level0, 3'd2);
        end
        drive(1'b0, 2'd0, 16'h0000, 4'b0001);
        #1;
        chk("cc_drain_a", out_data0, 16'h00C5);
        cyc();
        chk("cc_drain_b", out_data0, 16'h00C6);
        cyc();
        chk("cc_empty", level0, 3'd0);

        // Flush with levels 3,1,0,2 and a concurrent push/pop attempt
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 2'd0, 16'(16'h0D00 + k), 4'b0000); cyc();
        end
        drive(1'b1, 2'd1, 16'h0D10, 4'b0000); cyc();
        drive(1'b1, 2'd3, 16'h0D30, 4'b0000); cyc();
        drive(1'b1, 2'd3, 16'h0D31, 4'b0000); cyc();
        chk_levels("fl_levels_pre", {3'd2, 3'd0, 3'd1, 3'd3});
        flush = 1'b1;
        drive(1'b1, 2'd2, 16'h00EE, 4'b1111);
        #1;
        chk("fl_in_ready", in_ready, 1'b0);
        cyc();
        chk_levels("fl_levels", 12'h000);
        chk("fl_out_valid", out_valid, 4'b0000);
        flush = 1'b0;
        drive(1'b0, 2'd0, 16'h0000, 4'b0000);
        cyc();
        chk("fl_not_stored", out_valid, 4'b0000);

        // Asynchronous reset between edges with data resident
        drive(1'b1, 2'd1, 16'h5151, 4'b0000); cyc();
        drive(1'b1, 2'd3, 16'h5353, 4'b0000); cyc();
        drive(1'b0, 2'd0, 16'h0000, 4'b0000);
        chk("ar_pre_valid", out_valid, 4'b1010);
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_out_valid", out_valid, 4'b0000);
        chk("ar_out_data", {out_data3, out_data2, out_data1, out_data0}, 64'h0);
        chk("ar_busy", busy, 1'b0);
        chk_levels("ar_levels", 12'h000);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 2'd2, 16'h7777, 4'b0000);
        cyc();
        chk("ar_first_accept", {out_valid, out_data2}, {4'b0100, 16'h7777});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
